// File: rtl/mipspkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package     : mipspkg
//  Description : Shared MIPS core types. op_t is the 6-bit primary opcode
//                field of the instruction register. Any encoding not listed
//                here is an undefined opcode.
//  Revision    : 1.0  initial release
// ============================================================================
package mipspkg;

    typedef enum logic [5:0] {
        OP_RTYP  = 6'h00,
        OP_J     = 6'h02,
        OP_BEQZ  = 6'h04,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SUBI  = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } op_t;

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Multicycle control FSM for the MIPS core. Sequences one
//                shared ALU/memory datapath through fetch, decode, execute,
//                memory and writeback, handles variable-latency memory via a
//                ready handshake, counts retired instructions and traps on
//                undefined opcodes.
//  Ports       : clk, reset (async, active low)
//                op         - opcode field, sampled in DECODE
//                mem_ready  - memory completes current access this cycle
//                mem_req/memread/memwrite/iord        - memory control
//                irwrite/pcwrite/branch/pcsrc         - IR / PC control
//                alusrca/alusrcb/zeroextend/aluop     - ALU control
//                regdst/regwrite/memtoreg             - register file control
//                instr_done/instret                   - retirement pulse/count
//                trap                                 - undefined opcode seen
//  Revision    : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl
    import mipspkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  op_t              op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memread,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             branch,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             zeroextend,
    output logic [3:0]       aluop,
    output logic             regdst,
    output logic             regwrite,
    output logic             memtoreg,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret,
    output logic             trap
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_IMMEX  = 4'd4,
        S_IMMWB  = 4'd5,
        S_MEMADR = 4'd6,
        S_MEMRD  = 4'd7,
        S_MEMWB  = 4'd8,
        S_MEMWR  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_LUI  = 4'b0111;
    localparam logic [3:0] ALU_FUNC = 4'b1111;

    state_t           state_q, state_d;
    op_t              op_q;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    // ------------------------------------------------------------------------
    // State, captured opcode and retirement counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            op_q      <= OP_RTYP;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            // The IR may change after DECODE, so later states use this copy.
            if (state_q == S_DECODE) begin
                op_q <= op;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign instret = instret_q;

    // ------------------------------------------------------------------------
    // Next state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        zeroextend = 1'b0;
        aluop      = ALU_ADD;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        memtoreg   = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;

        // While reset is held the state register already sits in FETCH; the
        // strobes are suppressed so nothing is requested or written.
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    // IR and PC load only on the cycle the fetch completes.
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut.
                    alusrcb = 2'b11;
                    case (op)
                        OP_RTYP:        state_d = S_EXEC;
                        OP_LW, OP_SW:   state_d = S_MEMADR;
                        OP_BEQZ:        state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        OP_ADDI, OP_ADDIU, OP_SUBI, OP_SLTI,
                        OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                                        state_d = S_IMMEX;
                        default:        state_d = S_TRAP;
                    endcase
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = ALU_FUNC;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_IMMEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    // Logical ops and LUI take a zero-extended immediate.
                    case (op_q)
                        OP_SUBI: aluop = ALU_SUB;
                        OP_SLTI: aluop = ALU_SLT;
                        OP_ANDI: begin aluop = ALU_AND; zeroextend = 1'b1; end
                        OP_ORI:  begin aluop = ALU_OR;  zeroextend = 1'b1; end
                        OP_XORI: begin aluop = ALU_XOR; zeroextend = 1'b1; end
                        OP_LUI:  begin aluop = ALU_LUI; zeroextend = 1'b1; end
                        default: aluop = ALU_ADD;
                    endcase
                    state_d = S_IMMWB;
                end
                S_IMMWB: begin
                    regwrite = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    memread = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    memwrite = 1'b1;
                    iord     = 1'b1;
                    // A store retires the moment memory accepts it.
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = ALU_SUB;
                    branch  = 1'b1;
                    pcsrc   = 2'b01;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_JUMP: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_TRAP: begin
                    trap    = 1'b1;
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign instr_done = retire;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mips_multicycle_ctrl
//  Description : Self-checking bench for mips_multicycle_ctrl. Each
//                instruction is expanded from its class into the expected
//                per-cycle control word sequence; unused inputs are randomised.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_ctrl;
    import mipspkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    op_t              op;
    logic             mem_ready;
    logic             mem_req, memread, memwrite, iord, irwrite, pcwrite;
    logic             branch, alusrca, zeroextend, regdst, regwrite, memtoreg;
    logic             instr_done, trap;
    logic [1:0]       pcsrc, alusrcb;
    logic [3:0]       aluop;
    logic [CNT_W-1:0] instret;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memread    (memread),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .zeroextend (zeroextend),
        .aluop      (aluop),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .memtoreg   (memtoreg),
        .instr_done (instr_done),
        .instret    (instret),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       trap;
        logic       instr_done;
        logic       memtoreg;
        logic       regwrite;
        logic       regdst;
        logic [3:0] aluop;
        logic       zeroextend;
        logic [1:0] alusrcb;
        logic       alusrca;
        logic [1:0] pcsrc;
        logic       branch;
        logic       pcwrite;
        logic       irwrite;
        logic       iord;
        logic       memwrite;
        logic       memread;
        logic       mem_req;
    } ctl_t;

    ctl_t obs;
    assign obs = {trap, instr_done, memtoreg, regwrite, regdst, aluop, zeroextend,
                  alusrcb, alusrca, pcsrc, branch, pcwrite, irwrite, iord,
                  memwrite, memread, mem_req};

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    int guard;

    op_t vops [13] = '{OP_RTYP, OP_J, OP_BEQZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SUBI,
                       OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW};

    function automatic op_t rnd_op();
        return op_t'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    // {aluop, zeroextend} for immediate-class instructions
    function automatic logic [4:0] imm_ctl(op_t o);
        case (o)
            OP_SUBI: return 5'b0001_0;
            OP_SLTI: return 5'b0010_0;
            OP_ANDI: return 5'b0100_1;
            OP_ORI:  return 5'b0101_1;
            OP_XORI: return 5'b0110_1;
            OP_LUI:  return 5'b0111_1;
            default: return 5'b0000_0;
        endcase
    endfunction

    task automatic check_ctl(input string tag, input ctl_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
        logic [CNT_W-1:0] e;
        e = exp_cnt[CNT_W-1:0];
        n_checks++;
        assert (instret === e) else begin
            n_errors++;
            $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, e);
        end
    endtask

    // Called at posedge+1: drive, sample mid-cycle, then advance one clock.
    task automatic cyc(input logic rdy, input op_t o, input ctl_t exp, input string tag);
        mem_ready = rdy;
        op        = o;
        #3;
        check_ctl(tag, exp);
        check_cnt(tag);
        if (exp.instr_done) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b0;
        mem_ready = rnd_bit();
        op        = rnd_op();
        #3;
        exp_cnt = 0;
        check_ctl(tag, '0);
        check_cnt(tag);
        @(posedge clk);
        #1;
        check_ctl(tag, '0);
        reset = 1'b1;
    endtask

    task automatic run_instr(input op_t o, input int fw, input int mw,
                             input bit abort, input string tag);
        ctl_t e;
        e = '0; e.mem_req = 1'b1; e.memread = 1'b1; e.alusrcb = 2'b01;
        for (int i = 0; i < fw; i++) cyc(1'b0, rnd_op(), e, {tag, ":fetchwait"});
        e.irwrite = 1'b1; e.pcwrite = 1'b1;
        cyc(1'b1, rnd_op(), e, {tag, ":fetch"});
        e = '0; e.alusrcb = 2'b11;
        cyc(rnd_bit(), o, e, {tag, ":decode"});
        case (o)
            OP_RTYP: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 4'b1111;
                cyc(rnd_bit(), rnd_op(), e, {tag, ":exec"});
                e = '0; e.regdst = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
                cyc(rnd_bit(), rnd_op(), e, {tag, ":aluwb"});
            end
            OP_LW, OP_SW: begin
                e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
                cyc(rnd_bit(), rnd_op(), e, {tag, ":memadr"});
                e = '0; e.mem_req = 1'b1; e.iord = 1'b1;
                if (o == OP_LW) e.memread = 1'b1; else e.memwrite = 1'b1;
                for (int i = 0; i < mw; i++) cyc(1'b0, rnd_op(), e, {tag, ":memwait"});
                if (abort) begin
                    do_reset({tag, ":abort"});
                end else if (o == OP_LW) begin
                    cyc(1'b1, rnd_op(), e, {tag, ":memrd"});
                    e = '0; e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
                    cyc(rnd_bit(), rnd_op(), e, {tag, ":memwb"});
                end else begin
                    e.instr_done = 1'b1;
                    cyc(1'b1, rnd_op(), e, {tag, ":memwr"});
                end
            end
            OP_BEQZ: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 4'b0001; e.branch = 1'b1;
                e.pcsrc = 2'b01; e.instr_done = 1'b1;
                cyc(rnd_bit(), rnd_op(), e, {tag, ":branch"});
            end
            OP_J: begin
                e = '0; e.pcwrite = 1'b1; e.pcsrc = 2'b10; e.instr_done = 1'b1;
                cyc(rnd_bit(), rnd_op(), e, {tag, ":jump"});
            end
            OP_ADDI, OP_ADDIU, OP_SUBI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
                {e.aluop, e.zeroextend} = imm_ctl(o);
                cyc(rnd_bit(), rnd_op(), e, {tag, ":immex"});
                e = '0; e.regwrite = 1'b1; e.instr_done = 1'b1;
                cyc(rnd_bit(), rnd_op(), e, {tag, ":immwb"});
            end
            default: begin
                e = '0; e.trap = 1'b1;
                for (int i = 0; i < 20; i++) cyc(rnd_bit(), rnd_op(), e, {tag, ":trap"});
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b1;
        op        = OP_RTYP;
        @(posedge clk);
        #1;
        do_reset("reset");

        run_instr(OP_RTYP, 0, 0, 1'b0, "rtyp");
        run_instr(OP_LW,   0, 2, 1'b0, "lw");
        run_instr(OP_ORI,  0, 0, 1'b0, "ori");
        run_instr(OP_SUBI, 0, 0, 1'b0, "subi");
        run_instr(OP_SLTI, 0, 0, 1'b0, "slti");
        run_instr(OP_BEQZ, 0, 0, 1'b0, "beqz");
        run_instr(OP_J,    0, 0, 1'b0, "j");
        run_instr(op_t'(6'h3F), 1, 0, 1'b0, "undef");
        do_reset("trapreset");
        run_instr(OP_SW,   2, 1, 1'b0, "sw_after_trap");

        for (int n = 0; n < 40; n++) begin
            run_instr(vops[$urandom_range(0, 12)], $urandom_range(0, 2),
                      $urandom_range(0, 2), 1'b0, "rand");
        end

        guard = 0;
        while (exp_cnt != (1 << CNT_W) - 1 && guard < 20) begin
            run_instr(OP_ADDI, 0, 0, 1'b0, "fill");
            guard++;
        end
        run_instr(OP_SW,   1, 1, 1'b0, "sw_wrap");
        run_instr(OP_RTYP, 0, 0, 1'b0, "post_wrap");

        run_instr(OP_SW,   0, 1, 1'b1, "sw_abort");
        run_instr(OP_LUI,  0, 0, 1'b0, "recover");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
